axi_write_controller: RTL and testbench

//   Write-direction companion to the read-side interconnect controller: arbitrates AW/W/B for 2 masters onto 2 slaves.

---
 rtl/axi_write_controller.sv | 143 ++++++++++++++
 tb/tb_axi_write_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_controller.sv
// axi_write_controller: 2x2 AXI write-channel arbiter/router with internal DECERR sink for unmapped addresses
module axi_write_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clkk,
    input  logic                  resett,
    input  logic [ADDR_WIDTH-1:0] slave0_addr1,
    input  logic [ADDR_WIDTH-1:0] slave0_addr2,
    input  logic [ADDR_WIDTH-1:0] slave1_addr1,
    input  logic [ADDR_WIDTH-1:0] slave1_addr2,
    input  logic [ADDR_WIDTH-1:0] M0_AWADDR,
    input  logic [ADDR_WIDTH-1:0] M1_AWADDR,
    input  logic                  M0_AWVALID,
    input  logic                  M1_AWVALID,
    input  logic                  M0_WVALID,
    input  logic                  M1_WVALID,
    input  logic                  M0_WLAST,
    input  logic                  M1_WLAST,
    input  logic                  M0_BREADY,
    input  logic                  M1_BREADY,
    input  logic                  S0_AWREADY,
    input  logic                  S1_AWREADY,
    input  logic                  S0_WREADY,
    input  logic                  S1_WREADY,
    input  logic                  S0_BVALID,
    input  logic                  S1_BVALID,
    output logic                  M0_AWREADY,
    output logic                  M1_AWREADY,
    output logic                  M0_WREADY,
    output logic                  M1_WREADY,
    output logic                  M0_BVALID,
    output logic                  M1_BVALID,
    output logic                  S0_AWVALID,
    output logic                  S1_AWVALID,
    output logic                  S0_WVALID,
    output logic                  S1_WVALID,
    output logic                  S0_BREADY,
    output logic                  S1_BREADY,
    output logic                  select_master_write,
    output logic                  select_slave_write,
    output logic                  bresp_err,
    output logic [CNT_WIDTH-1:0]  wbeat_cnt
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, ERR_ADDR, ERR_DATA, ERR_RESP} state_t;
    state_t state, state_nxt;
    logic g, sel, last_grant;
    logic [CNT_WIDTH-1:0] cnt;
    logic awv_s, awr_m, wv_s, wr_m, bv_m, br_s;
    logic m_awv, m_wv, m_wlast, m_br, s_awr, s_wr, s_bv;
    logic req, gn, hit0, hit1;
    logic [ADDR_WIDTH-1:0] ga;
    assign m_awv   = g ? M1_AWVALID : M0_AWVALID;
    assign m_wv    = g ? M1_WVALID : M0_WVALID;
    assign m_wlast = g ? M1_WLAST : M0_WLAST;
    assign m_br    = g ? M1_BREADY : M0_BREADY;
    assign s_awr   = sel ? S1_AWREADY : S0_AWREADY;
    assign s_wr    = sel ? S1_WREADY : S0_WREADY;
    assign s_bv    = sel ? S1_BVALID : S0_BVALID;
    // Round-robin on a tie: the master that did not win last time gets the grant.
    assign req  = M0_AWVALID | M1_AWVALID;
    assign gn   = (M0_AWVALID && M1_AWVALID) ? ~last_grant : M1_AWVALID;
    assign ga   = gn ? M1_AWADDR : M0_AWADDR;
    assign hit0 = ga >= slave0_addr1 && ga <= slave0_addr2;
    assign hit1 = ga >= slave1_addr1 && ga <= slave1_addr2;
    always_comb begin
        state_nxt = state;
        awv_s = 1'b0;
        awr_m = 1'b0;
        wv_s  = 1'b0;
        wr_m  = 1'b0;
        bv_m  = 1'b0;
        br_s  = 1'b0;
        case (state)
            IDLE:     state_nxt = !req ? IDLE : (hit0 || hit1) ? ADDR : ERR_ADDR;
            ADDR: begin
                awv_s = m_awv;
                awr_m = s_awr;
                state_nxt = (m_awv && s_awr) ? DATA : ADDR;
            end
            DATA: begin
                wv_s = m_wv;
                wr_m = s_wr;
                state_nxt = (m_wv && s_wr && m_wlast) ? RESP : DATA;
            end
            RESP: begin
                bv_m = s_bv;
                br_s = m_br;
                state_nxt = (s_bv && m_br) ? IDLE : RESP;
            end
            ERR_ADDR: begin
                awr_m = m_awv;
                state_nxt = m_awv ? ERR_DATA : ERR_ADDR;
            end
            ERR_DATA: begin
                wr_m = 1'b1;
                state_nxt = (m_wv && m_wlast) ? ERR_RESP : ERR_DATA;
            end
            ERR_RESP: begin
                bv_m = 1'b1;
                state_nxt = m_br ? IDLE : ERR_RESP;
            end
            default:  state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clkk) begin
        if (resett) begin
            state      <= IDLE;
            g          <= 1'b0;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                g   <= gn;
                sel <= !hit0;
            end
            if ((state == ADDR || state == ERR_ADDR) && m_awv && awr_m)
                cnt <= '0;
            if ((state == DATA || state == ERR_DATA) && m_wv && wr_m)
                cnt <= cnt + 1'b1;
            if (state != IDLE && state_nxt == IDLE)
                last_grant <= g;
        end
    end
    assign M0_AWREADY = !g && awr_m;
    assign M1_AWREADY = g && awr_m;
    assign M0_WREADY  = !g && wr_m;
    assign M1_WREADY  = g && wr_m;
    assign M0_BVALID  = !g && bv_m;
    assign M1_BVALID  = g && bv_m;
    assign S0_AWVALID = !sel && awv_s;
    assign S1_AWVALID = sel && awv_s;
    assign S0_WVALID  = !sel && wv_s;
    assign S1_WVALID  = sel && wv_s;
    assign S0_BREADY  = !sel && br_s;
    assign S1_BREADY  = sel && br_s;
    assign select_master_write = g;
    assign select_slave_write  = sel;
    assign bresp_err = state == ERR_RESP;
    assign wbeat_cnt = cnt;
endmodule

// File: tb/tb_axi_write_controller.sv
// tb_axi_write_controller: randomized transaction-level check of the 2x2 write controller against a routing/arbitration model
module tb_axi_write_controller;
    logic clkk = 0, resett = 1;
    logic [31:0] s0a1 = 0, s0a2 = 32'hFF, s1a1 = 32'h1000, s1a2 = 32'h1FFF, m0a = 0, m1a = 0;
    logic m0awv = 0, m1awv = 0, m0wv = 0, m1wv = 0, m0wl = 0, m1wl = 0, m0br = 0, m1br = 0;
    logic s0awr = 0, s1awr = 0, s0wr = 0, s1wr = 0, s0bv = 0, s1bv = 0;
    logic M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY, M0_BVALID, M1_BVALID;
    logic S0_AWVALID, S1_AWVALID, S0_WVALID, S1_WVALID, S0_BREADY, S1_BREADY;
    logic select_master_write, select_slave_write, bresp_err;
    logic [7:0] wbeat_cnt;
    int errors = 0, checks = 0;
    bit lg = 1;

    axi_write_controller #(.ADDR_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clkk(clkk), .resett(resett),
        .slave0_addr1(s0a1), .slave0_addr2(s0a2), .slave1_addr1(s1a1), .slave1_addr2(s1a2),
        .M0_AWADDR(m0a), .M1_AWADDR(m1a), .M0_AWVALID(m0awv), .M1_AWVALID(m1awv),
        .M0_WVALID(m0wv), .M1_WVALID(m1wv), .M0_WLAST(m0wl), .M1_WLAST(m1wl),
        .M0_BREADY(m0br), .M1_BREADY(m1br), .S0_AWREADY(s0awr), .S1_AWREADY(s1awr),
        .S0_WREADY(s0wr), .S1_WREADY(s1wr), .S0_BVALID(s0bv), .S1_BVALID(s1bv),
        .M0_AWREADY(M0_AWREADY), .M1_AWREADY(M1_AWREADY), .M0_WREADY(M0_WREADY), .M1_WREADY(M1_WREADY),
        .M0_BVALID(M0_BVALID), .M1_BVALID(M1_BVALID), .S0_AWVALID(S0_AWVALID), .S1_AWVALID(S1_AWVALID),
        .S0_WVALID(S0_WVALID), .S1_WVALID(S1_WVALID), .S0_BREADY(S0_BREADY), .S1_BREADY(S1_BREADY),
        .select_master_write(select_master_write), .select_slave_write(select_slave_write),
        .bresp_err(bresp_err), .wbeat_cnt(wbeat_cnt)
    );

    always #5 clkk = ~clkk;

    function automatic int decode(input logic [31:0] a);
        return (a >= s0a1 && a <= s0a2) ? 0 : (a >= s1a1 && a <= s1a2) ? 1 : 2;
    endfunction

    function automatic logic [1:0] onehot(input int i);
        return i == 0 ? 2'b01 : i == 1 ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 2))
            0: return 32'($urandom_range(0, 255));
            1: return 32'h1000 + 32'($urandom_range(0, 32'hFFF));
            default: return 32'h5000 + 32'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic step();
        @(posedge clkk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        logic [22:0] v;
        v = {M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY, M0_BVALID, M1_BVALID, S0_AWVALID, S1_AWVALID,
             S0_WVALID, S1_WVALID, S0_BREADY, S1_BREADY, select_master_write, select_slave_write, bresp_err, wbeat_cnt};
        checks++;
        if (v !== 23'd0) begin errors++; $display("FAIL %s all_zero: got %b want 0", nm, v); end
    endtask

    // One full write: model picks the grant (round-robin) and the route (range decode), bench plays the slaves.
    task automatic run_txn(input bit r0, input bit r1, input logic [31:0] a0, input logic [31:0] a1,
                           input int beats, input bit tog, input string nm);
        bit eg, wv, swr, sbv, mbr, done, ewr, ebv;
        int er, cnt, guard;
        eg = (r0 && r1) ? !lg : r1;
        er = decode(eg ? a1 : a0);
        m0a = a0; m1a = a1; m0awv = r0; m1awv = r1;
        m0wv = 0; m1wv = 0; m0wl = 0; m1wl = 0; m0br = 0; m1br = 0;
        s0awr = 1; s1awr = 1; s0wr = 1; s1wr = 1; s0bv = 0; s1bv = 0;
        #1;
        checks++;
        if ({S1_AWVALID, S0_AWVALID, M1_AWREADY, M0_AWREADY} !== 4'b0) begin
            errors++; $display("FAIL %s idle_latency: got %b want 0000", nm, {S1_AWVALID, S0_AWVALID, M1_AWREADY, M0_AWREADY});
        end
        step();
        m0a = $urandom; m1a = $urandom;
        #1;
        checks++;
        if (select_master_write !== eg) begin errors++; $display("FAIL %s sel_master: got %b want %b", nm, select_master_write, eg); end
        checks++;
        if ({S1_AWVALID, S0_AWVALID} !== onehot(er)) begin
            errors++; $display("FAIL %s aw_route: got %b want %b", nm, {S1_AWVALID, S0_AWVALID}, onehot(er));
        end
        if (er < 2) begin
            checks++;
            if (select_slave_write !== er[0]) begin errors++; $display("FAIL %s sel_slave: got %b want %b", nm, select_slave_write, er[0]); end
        end
        checks++;
        if ({M1_AWREADY, M0_AWREADY} !== onehot(int'(eg))) begin
            errors++; $display("FAIL %s awready: got %b want %b", nm, {M1_AWREADY, M0_AWREADY}, onehot(int'(eg)));
        end
        step();
        if (eg) m1awv = 0; else m0awv = 0;
        cnt = 0; guard = 0; s0bv = 1; s1bv = 1;
        while (cnt < beats && guard < beats * 8 + 50) begin
            wv = $urandom_range(0, 3) != 0;
            swr = tog ? (guard % 2 == 0) : 1'b1;
            s0wr = swr; s1wr = swr;
            if (eg) begin m1wv = wv; m1wl = cnt == beats - 1; end
            else begin m0wv = wv; m0wl = cnt == beats - 1; end
            #1;
            ewr = (er == 2) ? 1'b1 : swr;
            checks++;
            if ({M1_WREADY, M0_WREADY} !== (ewr ? onehot(int'(eg)) : 2'b00)) begin
                errors++; $display("FAIL %s wready: got %b want %b", nm, {M1_WREADY, M0_WREADY}, ewr ? onehot(int'(eg)) : 2'b00);
            end
            checks++;
            if ({S1_WVALID, S0_WVALID} !== (wv ? onehot(er) : 2'b00)) begin
                errors++; $display("FAIL %s wvalid_route: got %b want %b", nm, {S1_WVALID, S0_WVALID}, wv ? onehot(er) : 2'b00);
            end
            checks++;
            if ({M1_BVALID, M0_BVALID, bresp_err} !== 3'b0) begin
                errors++; $display("FAIL %s early_resp: got %b want 000", nm, {M1_BVALID, M0_BVALID, bresp_err});
            end
            step();
            if (wv && ewr) cnt++;
            guard++;
            checks++;
            if (wbeat_cnt !== 8'(cnt)) begin errors++; $display("FAIL %s wbeat_cnt: got %0d want %0d", nm, wbeat_cnt, 8'(cnt)); end
        end
        checks++;
        if (cnt != beats) begin errors++; $display("FAIL %s w_timeout: got %0d beats want %0d", nm, cnt, beats); end
        m0wv = 0; m1wv = 0; m0wl = 0; m1wl = 0; s0bv = 0; s1bv = 0;
        done = 0; guard = 0;
        while (!done && guard < 50) begin
            sbv = $urandom_range(0, 1); mbr = $urandom_range(0, 1);
            s0bv = sbv; s1bv = sbv;
            if (eg) m1br = mbr; else m0br = mbr;
            #1;
            ebv = (er == 2) ? 1'b1 : sbv;
            checks++;
            if ({M1_BVALID, M0_BVALID, bresp_err} !== {ebv ? onehot(int'(eg)) : 2'b00, er == 2}) begin
                errors++; $display("FAIL %s bvalid: got %b want %b", nm, {M1_BVALID, M0_BVALID, bresp_err}, {ebv ? onehot(int'(eg)) : 2'b00, er == 2});
            end
            checks++;
            if ({S1_BREADY, S0_BREADY} !== (mbr ? onehot(er) : 2'b00)) begin
                errors++; $display("FAIL %s bready_route: got %b want %b", nm, {S1_BREADY, S0_BREADY}, mbr ? onehot(er) : 2'b00);
            end
            done = ebv && mbr;
            step();
            guard++;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL %s b_timeout: got no handshake want one", nm); end
        lg = eg;
        m0br = 0; m1br = 0; s0bv = 0; s1bv = 0;
        #1;
        checks++;
        if (select_master_write !== eg) begin errors++; $display("FAIL %s sel_hold: got %b want %b", nm, select_master_write, eg); end
    endtask

    task automatic test_reset();
        resett = 1;
        step(); step();
        resett = 0;
        lg = 1;
        #1;
        check_all_zero("reset");
    endtask

    task automatic test_arbitration();
        run_txn(1, 1, 32'h10, 32'h1010, 2, 0, "tie1");
        run_txn(0, 1, 32'h10, 32'h1010, 3, 0, "m1_after_tie");
        run_txn(1, 1, 32'h20, 32'h1020, 1, 0, "tie2");
    endtask

    task automatic test_boundaries();
        run_txn(1, 0, 32'hFF, 0, 1, 0, "s0_high");
        run_txn(0, 1, 0, 32'h100, 1, 0, "gap_unmapped");
        run_txn(1, 0, 32'h1000, 0, 2, 0, "s1_low");
        run_txn(0, 1, 0, 32'h1FFF, 1, 0, "s1_high");
        run_txn(1, 0, 32'h2000, 0, 1, 0, "above_s1");
    endtask

    task automatic test_reset_mid();
        m0a = 32'h10; m0awv = 1; m1awv = 0; s0awr = 1; s0wr = 1;
        step(); step();
        m0awv = 0; m0wv = 1; m0wl = 0;
        step(); step();
        checks++;
        if (wbeat_cnt !== 8'd2) begin errors++; $display("FAIL reset_mid pre_cnt: got %0d want 2", wbeat_cnt); end
        resett = 1;
        step();
        #1;
        check_all_zero("reset_mid");
        resett = 0; m0wv = 0; lg = 1;
        run_txn(1, 0, 32'h40, 0, 3, 0, "after_reset");
    endtask

    task automatic test_overlap();
        s1a1 = 0; s1a2 = 32'hFF;
        run_txn(1, 0, 32'h20, 0, 2, 0, "overlap_m0");
        run_txn(0, 1, 0, 32'h20, 1, 0, "overlap_m1");
        s1a1 = 32'h1000; s1a2 = 32'h1FFF;
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(1, 3);
            run_txn(r[0], r[1], rand_addr(), rand_addr(), $urandom_range(1, 6), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        run_txn(1, 0, 32'h10, 0, 4, 0, "m0_s0_4beat");
        test_arbitration();
        run_txn(0, 1, 0, 32'h5000, 2, 0, "m1_decerr");
        run_txn(0, 1, 0, 32'h1800, 8, 1, "m1_s1_toggle");
        test_boundaries();
        run_txn(1, 0, 32'h30, 0, 258, 0, "cnt_wrap");
        test_reset_mid();
        test_overlap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
